// File: rtl/sdram_resp_model_if.sv
// Request/response bus between a DRAM front-end (master) and the
// block-RAM responder (slave).
interface sdram_resp_model_if;
  logic        read_a;
  logic        write;
  logic        refresh;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  mask;
  logic [31:0] dout_a;
  logic        busy;
  logic        mem_initialized;
  logic        fail;
  logic [31:0] total_written;

  modport master (
    output read_a, write, refresh, addr, din, mask,
    input  dout_a, busy, mem_initialized, fail, total_written
  );

  modport slave (
    input  read_a, write, refresh, addr, din, mask,
    output dout_a, busy, mem_initialized, fail, total_written
  );
endinterface

// File: rtl/sdram_resp_model.sv
// Block-RAM stand-in for the SDRAM memory controller: fixed per-op busy
// latency, byte-masked writes, refresh watchdog and a sticky protocol fail flag.
module sdram_resp_model #(
  parameter int MEM_WORDS   = 4096,
  parameter int READ_LAT    = 4,
  parameter int WRITE_LAT   = 3,
  parameter int REFRESH_LAT = 6,
  parameter int INIT_CYCLES = 16,
  parameter int REFRESH_MAX = 405
) (
  input  logic                clk,
  input  logic                rst_x,
  sdram_resp_model_if.slave   mc
);
  localparam int AW      = $clog2(MEM_WORDS);
  localparam int MAXLAT0 = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int MAXLAT  = (MAXLAT0 > REFRESH_LAT) ? MAXLAT0 : REFRESH_LAT;
  localparam int LW      = ($clog2(MAXLAT) < 1) ? 1 : $clog2(MAXLAT);
  localparam int IW      = ($clog2(INIT_CYCLES) < 1) ? 1 : $clog2(INIT_CYCLES);
  localparam int WDW     = $clog2(REFRESH_MAX + 2);

  localparam logic [LW-1:0]  RD_L    = LW'(READ_LAT - 1);
  localparam logic [LW-1:0]  WR_L    = LW'(WRITE_LAT - 1);
  localparam logic [LW-1:0]  RF_L    = LW'(REFRESH_LAT - 1);
  localparam logic [IW-1:0]  INIT_L  = IW'(INIT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(REFRESH_MAX);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_OP} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_RF}     op_e;

  state_e          state_q;
  op_e             op_q;
  logic [LW-1:0]   lat_q;
  logic [IW-1:0]   init_q;
  logic [WDW-1:0]  wd_q;
  logic [29:0]     addr_q;
  logic [31:0]     din_q;
  logic [3:0]      mask_q;
  logic [31:0]     dout_q;
  logic [31:0]     tw_q;
  logic            busy_q, init_done_q, fail_q;

  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     ram_rd_q;

  logic any_req, multi_req, oor, done, ram_we;
  logic unused_addr;

  assign any_req   = mc.read_a | mc.write | mc.refresh;
  assign multi_req = (mc.read_a & mc.write) | (mc.read_a & mc.refresh) | (mc.write & mc.refresh);
  assign oor       = |addr_q[29:AW];
  assign done      = (state_q == ST_OP) && (lat_q == '0);
  assign ram_we    = done && (op_q == OP_WR) && !oor;
  assign unused_addr = ^mc.addr[1:0];

  // Read port samples the live address while idle so data is ready even for READ_LAT=1.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) ram_rd_q <= mem[mc.addr[AW+1:2]];
    for (int b = 0; b < 4; b++)
      if (ram_we && !mask_q[b]) mem[addr_q[AW-1:0]][8*b +: 8] <= din_q[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q     <= ST_INIT;
      op_q        <= OP_RD;
      lat_q       <= '0;
      init_q      <= '0;
      wd_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      mask_q      <= '1;
      dout_q      <= '0;
      tw_q        <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      if (state_q != ST_INIT && wd_q != '1) wd_q <= wd_q + 1'b1;
      if (REFRESH_MAX != 0 && init_done_q && wd_q > WD_MAX) fail_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          if (init_q == INIT_L) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            init_done_q <= 1'b1;
          end else begin
            init_q <= init_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (any_req) begin
            state_q <= ST_OP;
            busy_q  <= 1'b1;
            addr_q  <= mc.addr[31:2];
            din_q   <= mc.din;
            mask_q  <= mc.mask;
            if (multi_req) fail_q <= 1'b1;
            if (mc.refresh) begin
              op_q  <= OP_RF;
              lat_q <= RF_L;
              wd_q  <= '0;
            end else if (mc.write) begin
              op_q  <= OP_WR;
              lat_q <= WR_L;
            end else begin
              op_q  <= OP_RD;
              lat_q <= RD_L;
            end
          end
        end
        ST_OP: begin
          if (lat_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (op_q != OP_RF && oor) fail_q <= 1'b1;
            if (op_q == OP_RD) dout_q <= oor ? 32'h0 : ram_rd_q;
            if (op_q == OP_WR && !oor) tw_q <= tw_q + 32'd1;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign mc.dout_a          = dout_q;
  assign mc.busy            = busy_q;
  assign mc.mem_initialized = init_done_q;
  assign mc.fail            = fail_q;
  assign mc.total_written   = tw_q;
endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: init timing, byte masks, priority,
// range errors, refresh watchdog and reset in the middle of a write.
module tb_sdram_resp_model;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  sdram_resp_model_if mc();
  sdram_resp_model dut (.clk(clk), .rst_x(rst_x), .mc(mc));

  int compared   = 0;
  int mismatched = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Release reset just after a posedge; count negedges that still see busy.
  task automatic release_and_init(output int cnt);
    @(posedge clk);
    #1 rst_x = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (mc.busy !== 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Starts at a negedge with busy low; returns number of busy cycles seen.
  task automatic do_op(input logic rd, input logic wr, input logic rf,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int cnt);
    mc.read_a = rd; mc.write = wr; mc.refresh = rf;
    mc.addr = a; mc.din = d; mc.mask = m;
    @(negedge clk);
    mc.read_a = 1'b0; mc.write = 1'b0; mc.refresh = 1'b0;
    cnt = 0;
    while (mc.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_x = 1'b0;
    #1;
  endtask

  initial begin
    mc.read_a = 1'b0; mc.write = 1'b0; mc.refresh = 1'b0;
    mc.addr = '0; mc.din = '0; mc.mask = 4'hF;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, mc.busy}, 32'd1);
    chk("rst_init", {31'd0, mc.mem_initialized}, 32'd0);
    chk("rst_dout", mc.dout_a, 32'h0);
    chk("rst_fail", {31'd0, mc.fail}, 32'd0);
    chk("rst_tw", mc.total_written, 32'd0);

    release_and_init(n);
    chk("init_cycles", n, 32'd16);
    chk("init_done", {31'd0, mc.mem_initialized}, 32'd1);
    chk("init_fail", {31'd0, mc.fail}, 32'd0);

    // Full word write then read
    do_op(0, 1, 0, 32'h40, 32'hDEADBEEF, 4'b0000, n);
    chk("wr_lat", n, 32'd3);
    chk("wr_tw", mc.total_written, 32'd1);
    do_op(1, 0, 0, 32'h40, 32'h0, 4'hF, n);
    chk("rd_lat", n, 32'd4);
    chk("rd_full", mc.dout_a, 32'hDEADBEEF);

    // Byte masks
    do_op(0, 1, 0, 32'h42, 32'h11223344, 4'b1100, n);
    do_op(1, 0, 0, 32'h40, 32'h0, 4'hF, n);
    chk("rd_mask_lo", mc.dout_a, 32'hDEAD3344);
    do_op(0, 1, 0, 32'h40, 32'hAA000000, 4'b0111, n);
    do_op(1, 0, 0, 32'h40, 32'h0, 4'hF, n);
    chk("rd_mask_hi", mc.dout_a, 32'hAAAD3344);
    chk("tw_three", mc.total_written, 32'd3);
    chk("fail_clean", {31'd0, mc.fail}, 32'd0);

    // Refresh every ~200 cycles keeps the watchdog quiet
    do_op(0, 0, 1, 32'h0, 32'h0, 4'hF, n);
    chk("rf_lat", n, 32'd6);
    repeat (200) @(negedge clk);
    do_op(0, 0, 1, 32'h0, 32'h0, 4'hF, n);
    repeat (200) @(negedge clk);
    do_op(0, 0, 1, 32'h0, 32'h0, 4'hF, n);
    repeat (200) @(negedge clk);
    chk("wd_refreshed", {31'd0, mc.fail}, 32'd0);
    chk("rf_no_ram", mc.dout_a, 32'hAAAD3344);

    // Watchdog: starve refresh
    do_op(0, 0, 1, 32'h0, 32'h0, 4'hF, n);
    repeat (390) @(negedge clk);
    chk("wd_before", {31'd0, mc.fail}, 32'd0);
    repeat (30) @(negedge clk);
    chk("wd_expired", {31'd0, mc.fail}, 32'd1);

    // Priority / multi-request violation
    do_reset();
    chk("rst2_fail", {31'd0, mc.fail}, 32'd0);
    chk("rst2_dout", mc.dout_a, 32'h0);
    release_and_init(n);
    do_op(1, 1, 0, 32'h100, 32'h0BADF00D, 4'b0000, n);
    chk("prio_lat", n, 32'd3);
    chk("prio_fail", {31'd0, mc.fail}, 32'd1);
    chk("prio_tw", mc.total_written, 32'd1);
    do_op(1, 0, 0, 32'h100, 32'h0, 4'hF, n);
    chk("prio_rd", mc.dout_a, 32'h0BADF00D);

    // Range check: out-of-range write must not alias word 0
    do_reset();
    release_and_init(n);
    do_op(1, 0, 0, 32'h100, 32'h0, 4'hF, n);
    chk("ram_kept", mc.dout_a, 32'h0BADF00D);
    do_op(0, 1, 0, 32'h0, 32'h01020304, 4'b0000, n);
    do_op(0, 1, 0, 32'h4000, 32'hFFFFFFFF, 4'b0000, n);
    chk("oor_wr_lat", n, 32'd3);
    chk("oor_fail", {31'd0, mc.fail}, 32'd1);
    chk("oor_tw", mc.total_written, 32'd1);
    do_op(1, 0, 0, 32'h4000, 32'h0, 4'hF, n);
    chk("oor_rd_lat", n, 32'd4);
    chk("oor_rd", mc.dout_a, 32'h0);
    do_op(1, 0, 0, 32'h0, 32'h0, 4'hF, n);
    chk("no_alias", mc.dout_a, 32'h01020304);

    // Reset in the second busy cycle of a write
    do_reset();
    release_and_init(n);
    do_op(0, 1, 0, 32'h80, 32'h12345678, 4'b0000, n);
    do_op(1, 0, 0, 32'h80, 32'h0, 4'hF, n);
    chk("pre_abort_rd", mc.dout_a, 32'h12345678);
    mc.write = 1'b1; mc.addr = 32'h80; mc.din = 32'hCAFEF00D; mc.mask = 4'b0000;
    @(negedge clk);
    mc.write = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, mc.busy}, 32'd1);
    rst_x = 1'b0;
    #1;
    chk("abort_dout", mc.dout_a, 32'h0);
    chk("abort_tw", mc.total_written, 32'd0);
    release_and_init(n);
    chk("reinit_cycles", n, 32'd16);
    do_op(1, 0, 0, 32'h80, 32'h0, 4'hF, n);
    chk("abort_ram", mc.dout_a, 32'h12345678);
    chk("abort_tw2", mc.total_written, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sdram_resp_model.md
Name: sdram_resp_model

Overview:
- Synthesizable responder for the memory-controller request interface: the slave end that a DRAM front-end drives with read/write/refresh strobes, word address, write data and byte mask, and polls via busy.
- Backed by on-chip block RAM, with programmable per-operation latency and a refresh watchdog.
- Used as a drop-in replacement for the SDRAM MemoryController in FPGA bring-up and hardware-in-loop builds without external SDRAM, and as a protocol checker (fail flag).

Parameters:
- MEM_WORDS, 4096: number of 32-bit words; power of two. AW = clog2(MEM_WORDS).
- READ_LAT, 4: cycles busy stays high for a read; >=1.
- WRITE_LAT, 3: cycles busy stays high for a write; >=1.
- REFRESH_LAT, 6: cycles busy stays high for a refresh; >=1.
- INIT_CYCLES, 16: cycles after reset release before mem_initialized; >=1.
- REFRESH_MAX, 405: max cycles between refresh requests before fail; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_x  in  1  asynchronous active-low reset
- read_a  in  1  read request (level, held by initiator until busy seen high)
- write  in  1  write request (level, same rule)
- refresh  in  1  refresh request (level, same rule)
- addr  in  32  byte address; bits [1:0] ignored
- din  in  32  write data
- mask  in  4  active-low byte mask; mask[i]=0 writes byte i (din[8i+7:8i])
- dout_a  out  32  read data; valid from the first cycle busy is low after a read
- busy  out  1  responder occupied / not initialized
- mem_initialized  out  1  init sequence done
- fail  out  1  sticky protocol/range/watchdog error
- total_written  out  32  count of committed writes; wraps at 2^32

Behaviour:
- Reset (async assert, sync release): state=INIT, busy=1, mem_initialized=0, dout_a=0, fail=0, total_written=0, init and watchdog counters=0. RAM contents are not cleared.
- States: INIT, IDLE, OP, where OP carries the latched op code and a latency counter.
- INIT: count INIT_CYCLES edges, then go to IDLE. mem_initialized=1 and busy=0 from the first IDLE cycle. Requests during INIT are ignored; this is not an error.
- IDLE: requests are sampled only here.
  - On an edge with any request high: latch op, addr[31:2], din, mask; enter OP; busy=1 from the next cycle.
  - Priority: refresh > write > read.
  - More than one request high on the same edge sets fail; the winner is still executed.
- OP: busy stays high for exactly LAT cycles of the latched op, then IDLE with busy=0. Requests seen during OP are ignored; the initiator drops them after seeing busy.
- Read: RAM read at word addr[AW+1:2]; dout_a loads on the edge that drops busy and holds until the next read completes.
- Write: bytes with mask[i]=0 are committed on the edge that drops busy; total_written increments on that same edge. mask=4'b1111 commits nothing but still counts.
- Range check: if addr[31:2] >= MEM_WORDS, set fail. A write is dropped (not counted); a read returns 32'h0. Busy timing is unchanged.
- Refresh: no RAM effect. The watchdog counter clears on the edge the refresh is latched and otherwise increments, saturating. If REFRESH_MAX!=0 and the counter exceeds REFRESH_MAX while mem_initialized=1, set fail. The counter does not run during INIT.
- Reset mid-OP: operation aborted; an uncommitted write leaves RAM unchanged; dout_a returns to 0.
- fail clears only on reset.

Test Plan:
- Init: release reset -> busy=1, mem_initialized=0 for 16 cycles, then busy=0, mem_initialized=1, fail=0.
- Full word: write addr=0x40, din=0xDEADBEEF, mask=4'b0000; then read 0x40 -> busy high exactly 3 then 4 cycles; dout_a=0xDEADBEEF when busy falls; total_written=1.
- Byte mask: after the above, write addr=0x42 (word 0x10), din=0x11223344, mask=4'b1100 -> read 0x40 gives 0xDEAD3344. Then write mask=4'b0111, din=0xAA000000 -> read gives 0xAAAD3344.
- Priority/violation: read_a and write high on the same edge -> write executes (WRITE_LAT busy), fail=1. A later read returns the written data.
- Range/watchdog:
  - Write to addr=MEM_WORDS*4 -> fail=1, total_written unchanged, read of the same address returns 0.
  - Separately, no refresh for 406 cycles after init -> fail=1.
  - With a refresh every 200 cycles -> fail stays 0.
- Reset mid-write: assert rst_x low during the 2nd busy cycle of a write to 0x80 (old 0x12345678) -> after re-init, reading 0x80 returns 0x12345678 and total_written=0.
